// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries.
// Push and pop may coincide when full; flush overrides both.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  fetch_entry_t  mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC register, RUN/HALTED/FAULT FSM and prefetch buffer.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         push;
  logic         pop;
  logic         flush;
  logic         full;
  logic         empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fault     = (state_q == FAULT);
  assign wr_entry  = '{instr: imem_instr, pc: pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      // A misaligned target parks the fetcher in FAULT with the PC untouched.
      flush = 1'b1;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        state_d = FAULT;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            state_d = HALTED;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + 32'(INSTR_BYTES);
          end
        end
        HALTED:  if (!halt) state_d = RUN;
        FAULT:   state_d = FAULT;
        default: state_d = RUN;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .data  (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef FETCH_PERF_EN
  // A stall is a RUN cycle that wanted to fetch but found the buffer full.
  logic stall;
  assign stall = (state_q == RUN) && !halt && !redirect_valid && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch sequencer in front of the combinational, word-addressed instruction memory. It owns the fetch PC, drives the memory address, and captures returned instructions into a small prefetch buffer. The buffer is presented to decode through a valid/ready handshake. It handles branch/jump redirects, halt requests and misaligned-target faults, and sits between the instruction memory and the decode stage of the core.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- BUF_DEPTH, 2, prefetch entries; power of two, ≥2
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  instruction memory byte address (word aligned)
- imem_instr  in  32  instruction memory read data, valid in the same cycle as imem_addr
- redirect_valid  in  1  load new fetch target this cycle
- redirect_pc  in  32  new fetch target
- halt  in  1  stop issuing fetches while high
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  head instruction byte address
- fault  out  1  misaligned redirect seen; fetching stopped

## Operation
- State register `state`: RUN, HALTED, FAULT. Reset to RUN.
- imem_addr = fetch_pc at all times, as a combinational function of the register only.
- `push` = (state==RUN) && !halt && (!full || pop) && !redirect_valid.
- `pop` = out_valid && out_ready.
- On `push`:
  - write {imem_instr, fetch_pc} into the tail entry.
  - fetch_pc <= fetch_pc + 4. It wraps 32'hFFFF_FFFC -> 0, with no error.
- Simultaneous push and pop when full: both occur, and occupancy is unchanged.
- Redirect has priority over everything:
  - flush the buffer (occupancy 0); a pop in the same cycle is still a completed handshake.
  - If redirect_pc[1:0]==0: fetch_pc <= redirect_pc, state <= RUN, fault <= 0.
  - Else: state <= FAULT, fault <= 1, fetch_pc unchanged.
- RUN -> HALTED when halt=1 and no redirect. HALTED -> RUN when halt=0. In HALTED the buffer drains normally and fetch_pc holds.
- FAULT: no pushes and halt is ignored. FAULT is left only by an aligned redirect.
- out_instr/out_pc hold the head entry and are stable while out_valid && !out_ready. Their value is don't-care when out_valid=0.

## Timing
- Reset values: fetch_pc=RESET_PC, imem_addr=RESET_PC, occupancy 0, out_valid=0, fault=0, state RUN.
- Fetch-to-output latency is 1 cycle: the instruction at address A is pushed at edge N and is visible at out_* after edge N.
- First out_valid is the cycle after the first edge with rst_n high.
- Sustained throughput is 1 instruction/cycle with out_ready held high; there are no bubbles when full-and-popping.
- Redirect costs exactly 1 bubble: out_valid=0 in the cycle after the redirect edge, and the target instruction appears on the following edge.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous), and in-flight entries are discarded.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on each push.
  - perf_stall_cnt increments on each cycle in RUN with halt=0 and no push (buffer full).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

## Structure
- fetch_pkg:
  - fetch_state_t enum (RUN, HALTED, FAULT).
  - fetch_entry_t struct {instr, pc}.
  - constant INSTR_BYTES=4.
- Sub-module fetch_buffer: a BUF_DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, head.
  - Same-cycle push+pop is allowed when full; flush has priority.
- fetch_controller contains the PC register, FSM, push/pop logic and the optional counters.

## Test plan
- Reset, memory word i = 32'hA000_0000+i, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles from cycle 1, out_instr A000_0000..A000_0003.
- out_ready=0 for 6 cycles -> occupancy 2, imem_addr holds 8, out_pc holds 0. Then out_ready=1 -> out_pc 0,4,8 with no gap.
- Buffer full, redirect_valid with redirect_pc=0x40 and out_ready=1 -> head handshake completes, next cycle out_valid=0, then out_pc=0x40, out_instr=word 16.
- redirect_pc=0x42 -> fault=1, out_valid=0 next cycle, imem_addr frozen. Later redirect_pc=0x80 -> fault=0, out_pc=0x80 two cycles later.
- halt=1 with occupancy 2 and out_ready=1 -> two entries drain, then out_valid=0 and fetch_pc constant. halt=0 -> fetching resumes at the held address.
- FETCH_PERF_EN: 10 free-running fetches then 4 full-buffer cycles -> perf_fetch_cnt=10, perf_stall_cnt=4. rst_n pulse mid-run -> both counters 0, out_valid=0 immediately.
